mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register written by the ALU.
- Takes the ALU result as a load/store address, with the 4-bit mem_type access code, MemRead/MemWrite, store data, rd, RegWrite and MemToReg.
- Drives a request/grant/response data-memory port: byte-lane steering, sign/zero extension and a bus watchdog.
- Produces the registered MEM/WB result and a stall back to EX while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent waiting in REQ or WAIT_R before the access is aborted with o_bus_err (8-bit counter).

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  EX/MEM entry valid
i_ALUOutput  in  32  ALU result / memory byte address
i_write_reg  in  32  store data (rs2)
i_rd  in  5  destination register
i_RegWrite  in  1  writeback enable
i_MemToReg  in  1  1 = writeback loaded data, 0 = ALU result
i_MemRead  in  1  load
i_MemWrite  in  1  store
i_mem_type  in  4  0001 B, 0011 H, 1111 W, 1000 BU, 1100 HU
o_stall  out  1  hold EX/MEM inputs stable
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1 = write
o_dmem_addr  out  32  word address, {addr[31:2],2'b00}
o_dmem_be  out  4  byte enables
o_dmem_wdata  out  32  lane-replicated store data
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  32  read data
o_wb_valid  out  1  MEM/WB entry valid, one-cycle pulse
o_wb_rd  out  5  destination register
o_wb_RegWrite  out  1  writeback enable
o_wb_data  out  32  writeback value
o_misalign  out  1  misaligned/illegal access, pulses with o_wb_valid
o_bus_err  out  1  watchdog abort, pulses with o_wb_valid

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state IDLE, watchdog counter 0.
  - All outputs 0, including o_dmem_req, which drops immediately.
  - Any i_dmem_rvalid received while in IDLE is ignored.
- States: IDLE, REQ, WAIT_R.
- Access size from i_mem_type:
  - 0001/1000 = byte, 0011/1100 = half, 1111 = word.
  - Any other code with MemRead|MemWrite is illegal.
- Error check (evaluated in IDLE):
  - err when half with addr[0]=1, word with addr[1:0]!=0, illegal code, or MemRead&MemWrite both set.
  - err entries issue no request.
  - err entries give o_wb_valid=1 next edge with o_misalign=1 and o_wb_RegWrite=0.
- IDLE with i_valid and no memory op:
  - o_stall=0.
  - Next edge: o_wb_valid=1, o_wb_data=i_ALUOutput, rd/RegWrite passed through. Latency 1.
- IDLE with i_valid and a legal memory op:
  - o_stall=1.
  - Capture addr, data, size, signedness, rd, RegWrite, MemToReg.
  - Next edge: state REQ, o_dmem_req=1.
- Entering REQ, drive the registered memory port:
  - o_dmem_we=MemWrite.
  - be: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
  - wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- REQ:
  - o_dmem_req held with all port signals stable until i_dmem_gnt.
  - On gnt, store: req drops, o_stall=0 this cycle, next edge o_wb_valid=1 with RegWrite as captured, state IDLE. Store latency 2 cycles minimum.
  - On gnt, load: req drops, state WAIT_R, o_stall stays 1.
- WAIT_R:
  - rvalid is honoured only here; rvalid in the same cycle as gnt is ignored.
  - On i_dmem_rvalid: o_stall=0 this cycle.
  - Next edge: o_wb_valid=1, state IDLE.
  - o_wb_data is the lane-selected rdata, extended per type: B/H sign-extended, BU/HU zero-extended, W unchanged. MemToReg=0 selects the address instead.
  - Load latency 3 cycles minimum.
- Stall protocol:
  - Upstream holds its inputs while o_stall=1.
  - Inputs are ignored outside IDLE.
  - o_stall=0 in a completion cycle lets upstream advance on that edge.
- Watchdog:
  - Counter clears on entry to REQ/WAIT_R and increments each cycle in them.
  - At TIMEOUT_CYCLES: req drops, o_stall=0 that cycle.
  - Next edge: o_wb_valid=1, o_bus_err=1, RegWrite=0, state IDLE.
- o_wb_* hold their last value when o_wb_valid=0.
- o_misalign and o_bus_err are 0 on every normal completion.

Test Plan:
- Non-memory op: i_valid=1, ALUOutput=0x1234, rd=5, RegWrite=1 -> next edge o_wb_valid=1, o_wb_data=0x1234, o_stall never 1.
- LB at addr 0x103, rdata=0x80AABBCC -> be=1000, addr=0x100, o_wb_data=0xFFFFFF80. Same access as LBU -> 0x00000080. Both with gnt immediate and rvalid next cycle: wb_valid 3 cycles after accept.
- SH at addr 0x202, data=0xDEADBEEF -> be=1100, wdata=0xBEEFBEEF, we=1. Gnt held off 4 cycles: req and port signals stable, o_stall=1 throughout.
- LW at 0x101 -> no o_dmem_req, next edge o_wb_valid=1, o_misalign=1, o_wb_RegWrite=0. Repeat with mem_type=0101 -> same.
- TIMEOUT_CYCLES=4, gnt never asserted -> req drops after 4 cycles in REQ, o_bus_err pulses with o_wb_valid, then a normal access completes cleanly.
- Reset asserted while in WAIT_R -> o_dmem_req/o_stall/o_wb_valid 0 immediately; rvalid arriving after release does not produce o_wb_valid.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response port between the MEM stage and memory.
interface mem_access_stage_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: consumes the EX/MEM entry, runs loads/stores over the
// request/grant/response port with lane steering, extension and a watchdog,
// and produces the registered MEM/WB entry plus a stall back to EX.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_ALUOutput,
    input  logic [31:0] i_write_reg,
    input  logic [4:0]  i_rd,
    input  logic        i_RegWrite,
    input  logic        i_MemToReg,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [3:0]  i_mem_type,
    output logic        o_stall,
    mem_access_stage_if.master dmem,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_RegWrite,
    output logic [31:0] o_wb_data,
    output logic        o_misalign,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Watchdog fires in the cycle that completes TIMEOUT_CYCLES cycles of waiting.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    size_t       size_q, size_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic        stall_c;

    // Access-code decode of the incoming entry.
    logic is_b, is_h, is_w, is_uns, mem_op, acc_err, timeout;
    logic [3:0]  be_in;
    logic [31:0] wdata_in, lane_data, load_ext;

    assign is_b    = (i_mem_type == 4'b0001) || (i_mem_type == 4'b1000);
    assign is_h    = (i_mem_type == 4'b0011) || (i_mem_type == 4'b1100);
    assign is_w    = (i_mem_type == 4'b1111);
    assign is_uns  = (i_mem_type == 4'b1000) || (i_mem_type == 4'b1100);
    assign mem_op  = i_MemRead | i_MemWrite;
    assign acc_err = (!is_b && !is_h && !is_w)
                   || (is_h && i_ALUOutput[0])
                   || (is_w && (i_ALUOutput[1:0] != 2'b00))
                   || (i_MemRead && i_MemWrite);
    assign timeout = (wdog_q == WDOG_LAST);

    // Byte-lane enables and replicated store data for the captured access.
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = i_write_reg;
        if (is_b) begin
            be_in    = 4'b0001 << i_ALUOutput[1:0];
            wdata_in = {4{i_write_reg[7:0]}};
        end else if (is_h) begin
            be_in    = 4'b0011 << {i_ALUOutput[1], 1'b0};
            wdata_in = {2{i_write_reg[15:0]}};
        end
    end

    // Shift the addressed lane down to bit 0, then sign/zero extend by size.
    assign lane_data = dmem.i_dmem_rdata >> {addr_q[1:0], 3'b000};
    always_comb begin
        load_ext = dmem.i_dmem_rdata;
        case (size_q)
            SZ_B:    load_ext = uns_q ? {24'h0, lane_data[7:0]}
                                      : {{24{lane_data[7]}}, lane_data[7:0]};
            SZ_H:    load_ext = uns_q ? {16'h0, lane_data[15:0]}
                                      : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_ext = dmem.i_dmem_rdata;
        endcase
    end

    // Next-state, port and writeback logic; completion wins over the watchdog.
    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        uns_d         = uns_q;
        rd_d          = rd_q;
        regwrite_d    = regwrite_q;
        memtoreg_d    = memtoreg_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_data_d     = wb_data_q;
        misalign_d    = 1'b0;
        bus_err_d     = 1'b0;
        stall_c       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (!mem_op || acc_err) begin
                        wb_valid_d    = 1'b1;
                        wb_rd_d       = i_rd;
                        wb_data_d     = i_ALUOutput;
                        wb_regwrite_d = mem_op ? 1'b0 : i_RegWrite;
                        misalign_d    = mem_op;
                    end else begin
                        stall_c    = 1'b1;
                        state_d    = S_REQ;
                        wdog_d     = 8'd0;
                        req_d      = 1'b1;
                        we_d       = i_MemWrite;
                        addr_d     = i_ALUOutput;
                        be_d       = be_in;
                        wdata_d    = wdata_in;
                        size_d     = is_b ? SZ_B : (is_h ? SZ_H : SZ_W);
                        uns_d      = is_uns;
                        rd_d       = i_rd;
                        regwrite_d = i_RegWrite;
                        memtoreg_d = i_MemToReg;
                    end
                end
            end
            S_REQ: begin
                if (dmem.i_dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d       = S_IDLE;
                        wb_valid_d    = 1'b1;
                        wb_rd_d       = rd_q;
                        wb_regwrite_d = regwrite_q;
                        wb_data_d     = addr_q;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT_R;
                        wdog_d  = 8'd0;
                    end
                end else if (timeout) begin
                    req_d         = 1'b0;
                    state_d       = S_IDLE;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = rd_q;
                    wb_regwrite_d = 1'b0;
                    bus_err_d     = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    wdog_d  = wdog_q + 8'd1;
                end
            end
            S_WAIT_R: begin
                if (dmem.i_dmem_rvalid) begin
                    state_d       = S_IDLE;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = rd_q;
                    wb_regwrite_d = regwrite_q;
                    wb_data_d     = memtoreg_q ? load_ext : addr_q;
                end else if (timeout) begin
                    state_d       = S_IDLE;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = rd_q;
                    wb_regwrite_d = 1'b0;
                    bus_err_d     = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    wdog_d  = wdog_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured access and MEM/WB registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= S_IDLE;
            wdog_q        <= 8'd0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 32'h0;
            be_q          <= 4'h0;
            wdata_q       <= 32'h0;
            size_q        <= SZ_B;
            uns_q         <= 1'b0;
            rd_q          <= 5'h0;
            regwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'h0;
            wb_regwrite_q <= 1'b0;
            wb_data_q     <= 32'h0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            rd_q          <= rd_d;
            regwrite_q    <= regwrite_d;
            memtoreg_q    <= memtoreg_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_data_q     <= wb_data_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // Stall is forced low while reset is held so upstream sees all outputs at 0.
    assign o_stall           = stall_c & i_reset;
    assign dmem.o_dmem_req   = req_q;
    assign dmem.o_dmem_we    = we_q;
    assign dmem.o_dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem.o_dmem_be    = be_q;
    assign dmem.o_dmem_wdata = wdata_q;
    assign o_wb_valid        = wb_valid_q;
    assign o_wb_rd           = wb_rd_q;
    assign o_wb_RegWrite     = wb_regwrite_q;
    assign o_wb_data         = wb_data_q;
    assign o_misalign        = misalign_q;
    assign o_bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage against a behavioural access model.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_ALUOutput, i_write_reg;
    logic [4:0]  i_rd;
    logic        i_RegWrite, i_MemToReg, i_MemRead, i_MemWrite;
    logic [3:0]  i_mem_type;
    logic        o_stall, o_wb_valid, o_wb_RegWrite, o_misalign, o_bus_err;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;

    int checks = 0;
    int failures = 0;

    mem_access_stage_if dmem_if ();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_ALUOutput  (i_ALUOutput),
        .i_write_reg  (i_write_reg),
        .i_rd         (i_rd),
        .i_RegWrite   (i_RegWrite),
        .i_MemToReg   (i_MemToReg),
        .i_MemRead    (i_MemRead),
        .i_MemWrite   (i_MemWrite),
        .i_mem_type   (i_mem_type),
        .o_stall      (o_stall),
        .dmem         (dmem_if.master),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd      (o_wb_rd),
        .o_wb_RegWrite(o_wb_RegWrite),
        .o_wb_data    (o_wb_data),
        .o_misalign   (o_misalign),
        .o_bus_err    (o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One EX/MEM entry from acceptance to writeback; the memory side grants
    // after gnt_dly idle request cycles and returns data after rv_dly cycles.
    task automatic run_txn(input logic [3:0] mt, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic mr, input logic mw,
                           input int gnt_dly, input int rv_dly);
        int sz, e_lat, lat, req_cyc, rv_cyc, phase;
        logic mem, err, sgn, e_bus, done, prev_stall, ends, e_rw;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_load, mask, lane, e_data, held;

        // Reference model
        sz  = (mt == 4'b0001 || mt == 4'b1000) ? 1 :
              (mt == 4'b0011 || mt == 4'b1100) ? 2 : (mt == 4'b1111) ? 4 : 0;
        sgn = (mt == 4'b0001 || mt == 4'b0011);
        mem = mr | mw;
        err = 1'b0;
        if (mem) begin
            if (sz == 0 || (mr && mw)) err = 1'b1;
            else if ((addr % sz) != 0) err = 1'b1;
        end
        e_be    = 4'(((1 << sz) - 1) << (addr % 4));
        e_wdata = (sz == 1) ? (data & 32'hFF) * 32'h01010101 :
                  (sz == 2) ? (data & 32'hFFFF) * 32'h00010001 : data;
        lane    = rdata >> (8 * (addr % 4));
        mask    = (sz == 4) ? 32'hFFFFFFFF : (sz == 2) ? 32'hFFFF : 32'hFF;
        e_load  = lane & mask;
        if (sgn && sz < 4 && (e_load & ((mask >> 1) + 1)) != 0) e_load = e_load | ~mask;
        e_bus = 1'b0;
        if (!mem || err)        e_lat = 1;
        else if (gnt_dly >= TO) begin e_lat = 1 + TO; e_bus = 1'b1; end
        else if (mw)            e_lat = gnt_dly + 2;
        else if (rv_dly >= TO)  begin e_lat = gnt_dly + 2 + TO; e_bus = 1'b1; end
        else                    e_lat = gnt_dly + rv_dly + 3;
        e_data = (mem && m2r) ? e_load : addr;
        e_rw   = (err || e_bus) ? 1'b0 : rw;

        i_valid = 1'b1; i_ALUOutput = addr; i_write_reg = data; i_rd = rd;
        i_RegWrite = rw; i_MemToReg = m2r; i_MemRead = mr; i_MemWrite = mw;
        i_mem_type = mt;
        dmem_if.i_dmem_gnt = 1'b0; dmem_if.i_dmem_rvalid = 1'b0;
        #1;
        chk("stall_accept", o_stall, mem && !err);
        prev_stall = o_stall;
        lat = 0; req_cyc = 0; rv_cyc = 0; phase = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge i_clk);
            lat++;
            if (!prev_stall) i_valid = 1'b0;
            dmem_if.i_dmem_gnt    = 1'b0;
            dmem_if.i_dmem_rvalid = 1'b0;
            dmem_if.i_dmem_rdata  = $urandom;
            ends = 1'b0;
            if (o_wb_valid) begin
                done = 1'b1;
            end else if (phase == 0) begin
                req_cyc++;
                chk("req_on", dmem_if.o_dmem_req, 1);
                chk("port_addr", dmem_if.o_dmem_addr, addr & 32'hFFFFFFFC);
                chk("port_be", dmem_if.o_dmem_be, e_be);
                chk("port_we", dmem_if.o_dmem_we, mw);
                if (mw) chk("port_wdata", dmem_if.o_dmem_wdata, e_wdata);
                if (req_cyc > gnt_dly) begin
                    dmem_if.i_dmem_gnt = 1'b1;
                    if (mw) ends = 1'b1;
                    else begin
                        phase = 1;
                        dmem_if.i_dmem_rvalid = 1'($urandom_range(0, 1));
                    end
                end else if (req_cyc == TO) begin
                    ends = 1'b1;
                end
            end else begin
                rv_cyc++;
                chk("req_off", dmem_if.o_dmem_req, 0);
                if (rv_cyc > rv_dly) begin
                    dmem_if.i_dmem_rvalid = 1'b1;
                    dmem_if.i_dmem_rdata  = rdata;
                    ends = 1'b1;
                end else if (rv_cyc == TO) begin
                    ends = 1'b1;
                end
            end
            #1;
            if (!done) chk("stall", o_stall, !ends);
            prev_stall = o_stall;
        end
        dmem_if.i_dmem_gnt = 1'b0; dmem_if.i_dmem_rvalid = 1'b0;
        i_valid = 1'b0;
        if (!done) begin
            chk("wb_arrived", 0, 1);
        end else begin
            chk("latency", lat, e_lat);
            chk("wb_regwrite", o_wb_RegWrite, e_rw);
            chk("misalign", o_misalign, err);
            chk("bus_err", o_bus_err, e_bus);
            chk("req_idle", dmem_if.o_dmem_req, 0);
            if (!err && !e_bus) chk("wb_rd", o_wb_rd, rd);
            if (!mem || (mr && !err && !e_bus)) chk("wb_data", o_wb_data, e_data);
        end
        held = o_wb_data;
        @(negedge i_clk);
        chk("wb_pulse", o_wb_valid, 0);
        chk("wb_hold", o_wb_data, held);
        $display("txn mt=%b addr=%h r=%0b w=%0b gd=%0d rd=%0d lat=%0d err=%0b bus=%0b",
                 mt, addr, mr, mw, gnt_dly, rv_dly, lat, err, e_bus);
    endtask

    logic [3:0]  r_mt;
    logic [31:0] r_addr;
    int          r_op, r_gd, r_rd;
    logic [3:0]  legal_types [5];

    initial begin
        legal_types = '{4'b0001, 4'b0011, 4'b1111, 4'b1000, 4'b1100};
        i_reset = 1'b0; i_valid = 1'b0; i_ALUOutput = 0; i_write_reg = 0; i_rd = 0;
        i_RegWrite = 0; i_MemToReg = 0; i_MemRead = 0; i_MemWrite = 0; i_mem_type = 0;
        dmem_if.i_dmem_gnt = 0; dmem_if.i_dmem_rvalid = 0; dmem_if.i_dmem_rdata = 0;
        repeat (2) @(negedge i_clk);
        chk("rst_req", dmem_if.o_dmem_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_wb_data", o_wb_data, 0);
        chk("rst_be", dmem_if.o_dmem_be, 0);
        i_reset = 1'b1;
        @(negedge i_clk);

        // Directed cases
        run_txn(4'b1111, 32'h1234, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0);
        chk("alu_wb", o_wb_data, 32'h1234);
        run_txn(4'b0001, 32'h103, 0, 32'h80AABBCC, 5'd7, 1, 1, 1, 0, 0, 0);
        chk("lb_data", o_wb_data, 32'hFFFFFF80);
        run_txn(4'b1000, 32'h103, 0, 32'h80AABBCC, 5'd7, 1, 1, 1, 0, 0, 0);
        chk("lbu_data", o_wb_data, 32'h00000080);
        run_txn(4'b0011, 32'h202, 32'hDEADBEEF, 0, 5'd3, 0, 0, 0, 1, 3, 0);
        run_txn(4'b1111, 32'h101, 0, 0, 5'd9, 1, 1, 1, 0, 0, 0);
        run_txn(4'b0101, 32'h100, 0, 0, 5'd9, 1, 1, 1, 0, 0, 0);
        run_txn(4'b1111, 32'h300, 0, 32'h11223344, 5'd4, 1, 1, 1, 0, 100, 0);
        run_txn(4'b1111, 32'h300, 0, 32'h11223344, 5'd4, 1, 1, 1, 0, 0, 0);
        chk("lw_after_to", o_wb_data, 32'h11223344);
        run_txn(4'b1100, 32'h402, 0, 32'h9876ABCD, 5'd6, 1, 1, 1, 0, 1, 100);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) r_mt = 4'($urandom);
            else r_mt = legal_types[$urandom_range(0, 4)];
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r_mt == 4'b1111) r_addr[1:0] = 2'b00;
                else if (r_mt == 4'b0011 || r_mt == 4'b1100) r_addr[0] = 1'b0;
            end
            r_op = $urandom_range(0, 7);
            r_gd = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 3);
            r_rd = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 3);
            run_txn(r_mt, r_addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                    1'($urandom), (r_op >= 1 && r_op <= 3) || r_op == 7,
                    r_op >= 4, r_gd, r_rd);
        end

        // Reset while a load waits for data
        i_valid = 1'b1; i_ALUOutput = 32'h40; i_mem_type = 4'b1111;
        i_MemRead = 1'b1; i_MemWrite = 1'b0; i_MemToReg = 1'b1; i_RegWrite = 1'b1;
        @(negedge i_clk);
        chk("wr_req", dmem_if.o_dmem_req, 1);
        dmem_if.i_dmem_gnt = 1'b1;
        @(negedge i_clk);
        dmem_if.i_dmem_gnt = 1'b0;
        chk("wr_stall", o_stall, 1);
        #2;
        i_reset = 1'b0; i_valid = 1'b0;
        #1;
        chk("rst_async_req", dmem_if.o_dmem_req, 0);
        chk("rst_async_stall", o_stall, 0);
        chk("rst_async_wbv", o_wb_valid, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        dmem_if.i_dmem_rvalid = 1'b1;
        dmem_if.i_dmem_rdata = 32'hCAFEF00D;
        @(negedge i_clk);
        dmem_if.i_dmem_rvalid = 1'b0;
        chk("idle_rvalid_ignored", o_wb_valid, 0);
        @(negedge i_clk);
        chk("idle_rvalid_ignored2", o_wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
